// File: rtl/adc_scan_ctrl.sv
// -----------------------------------------------------------------------------
// adc_scan_ctrl
//
// Multi-channel ADC scan sequencer. It drives an external I2C byte engine.
// For every enabled channel it does three things:
//   1. Writes a channel-select config byte.
//   2. Reads RD_BYTES bytes.
//   3. Extracts a DATA_W-bit sample and stores it in a per-channel result
//      register.
// A scan is started by a one-shot start pulse, or it repeats periodically
// while auto_en is high. Every engine byte is guarded by a timeout.
//
// Optional build macro ADC_SCAN_AVG_EN: each channel is converted four times
// and the truncated average of the four samples is stored.
//
// Ports
//   clk, rst         : clock, asynchronous active-low reset (shared with engine)
//   start            : one-cycle pulse, begin a scan (ignored while busy)
//   auto_en          : rescan SCAN_GAP clocks after each scan ends
//   ch_mask          : channel enables, latched at scan start
//   busy, scan_done  : scan in progress / one-cycle end-of-scan pulse
//   sample_vld/_ch/_data : one-cycle notification of a stored result
//   rd_sel, rd_result: combinational result register read (0 when out of range)
//   err, err_ch      : timeout pulse / channel that timed out (held)
//   i2c_*            : byte engine command/data handshake
// -----------------------------------------------------------------------------
module adc_scan_ctrl #(
  parameter int          NUM_CH      = 4,
  parameter int          DATA_W      = 12,
  parameter int          RD_BYTES    = 2,
  parameter int          ALIGN_SHIFT = 4,
  parameter logic [6:0]  DEV_ID      = 7'h48,
  parameter logic [7:0]  CFG_BASE    = 8'h40,
  parameter int          SCAN_GAP    = 50000,
  parameter int          TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              auto_en,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              busy,
  output logic              scan_done,
  output logic              sample_vld,
  output logic [2:0]        sample_ch,
  output logic [DATA_W-1:0] sample_data,
  input  logic [2:0]        rd_sel,
  output logic [DATA_W-1:0] rd_result,
  output logic              err,
  output logic [2:0]        err_ch,
  output logic [4:0]        i2c_cmd,
  output logic              i2c_cmd_vld,
  output logic [7:0]        i2c_wr_data,
  input  logic [7:0]        i2c_rd_data,
  input  logic              i2c_rd_data_vld,
  input  logic              i2c_done
);

  localparam logic [2:0] LAST_CNT = 3'(3 + RD_BYTES - 1);
  localparam int         GAP_W    = $clog2(SCAN_GAP + 1);
  localparam int         TMO_W    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [4:0] CMD_START = 5'b00001;
  localparam logic [4:0] CMD_WRITE = 5'b00010;
  localparam logic [4:0] CMD_READ  = 5'b00100;
  localparam logic [4:0] CMD_STOP  = 5'b01000;
  localparam logic [4:0] CMD_ACK   = 5'b10000;

  typedef enum logic [2:0] {IDLE, SEL, ISSUE, WAIT, STORE, NEXT, GAP} state_t;

  state_t              state_reg;
  logic [NUM_CH-1:0]   mask_reg;
  logic [2:0]          ch_reg;
  logic [2:0]          cnt_reg;
  logic [TMO_W-1:0]    tmo_reg;
  logic [GAP_W-1:0]    gap_reg;
  logic [15:0]         shift_reg;
  logic [DATA_W-1:0]   result_reg [NUM_CH];
  logic [DATA_W-1:0]   result_pad [8];

  logic [2:0]          first_ch;
  logic [2:0]          next_ch;
  logic                next_found;
  logic                launch;
  logic [DATA_W-1:0]   sample;

`ifdef ADC_SCAN_AVG_EN
  logic [DATA_W+1:0]   acc_reg;
  logic [DATA_W+1:0]   acc_sum;
  logic [1:0]          conv_reg;
  assign acc_sum = acc_reg + {2'b00, sample};
`endif

  // Command and write byte for a given position in the per-channel sequence.
  // Intermediate read bytes are ACKed; the last one carries STOP so the
  // engine NACKs it.
  function automatic logic [12:0] byte_cmd(input logic [2:0] cnt, input logic [2:0] ch);
    logic [12:0] r;
    if (cnt == 3'd0)          r = {CMD_START | CMD_WRITE, DEV_ID, 1'b0};
    else if (cnt == 3'd1)     r = {CMD_WRITE, CFG_BASE | {5'd0, ch}};
    else if (cnt == 3'd2)     r = {CMD_START | CMD_WRITE, DEV_ID, 1'b1};
    else if (cnt == LAST_CNT) r = {CMD_READ | CMD_STOP, 8'h00};
    else                      r = {CMD_READ | CMD_ACK, 8'h00};
    return r;
  endfunction

  // The descending loop leaves the lowest qualifying index in first_ch/next_ch.
  always_comb begin
    first_ch   = '0;
    next_ch    = '0;
    next_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) first_ch = 3'(i);
      if (mask_reg[i] && (3'(i) > ch_reg)) begin
        next_found = 1'b1;
        next_ch    = 3'(i);
      end
    end
  end

  // A scan starts from IDLE on start, or from GAP on start or gap expiry.
  assign launch = ((state_reg == IDLE) && start) ||
                  ((state_reg == GAP) && (start || (auto_en && (gap_reg == GAP_W'(SCAN_GAP - 1)))));

  assign sample = DATA_W'(shift_reg >> ALIGN_SHIFT);

  // Pad the result bank to the full 3-bit select range so that out-of-range
  // selects read back zero without an out-of-bounds index.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pad
      if (gi < NUM_CH) begin : g_used
        assign result_pad[gi] = result_reg[gi];
      end else begin : g_zero
        assign result_pad[gi] = '0;
      end
    end
  endgenerate

  assign rd_result = result_pad[rd_sel];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      mask_reg    <= '0;
      ch_reg      <= '0;
      cnt_reg     <= '0;
      tmo_reg     <= '0;
      gap_reg     <= '0;
      shift_reg   <= '0;
      busy        <= 1'b0;
      scan_done   <= 1'b0;
      sample_vld  <= 1'b0;
      sample_ch   <= '0;
      sample_data <= '0;
      err         <= 1'b0;
      err_ch      <= '0;
      i2c_cmd     <= '0;
      i2c_cmd_vld <= 1'b0;
      i2c_wr_data <= '0;
      for (int i = 0; i < NUM_CH; i++) result_reg[i] <= '0;
`ifdef ADC_SCAN_AVG_EN
      acc_reg     <= '0;
      conv_reg    <= '0;
`endif
    end else begin
      scan_done   <= 1'b0;
      sample_vld  <= 1'b0;
      err         <= 1'b0;
      i2c_cmd_vld <= 1'b0;

      // Capturing independently of the FSM means a byte arriving together
      // with done is already in shift_reg when STORE evaluates.
      if (i2c_rd_data_vld) shift_reg <= {shift_reg[7:0], i2c_rd_data};

      if (launch) begin
        if (|ch_mask) begin
          mask_reg  <= ch_mask;
          ch_reg    <= first_ch;
          busy      <= 1'b1;
          state_reg <= SEL;
        end else begin
          // Empty scan: nothing to transfer, just report completion.
          scan_done <= 1'b1;
          gap_reg   <= '0;
          state_reg <= auto_en ? GAP : IDLE;
        end
      end else begin
        case (state_reg)
          IDLE: ;
          GAP: begin
            if (!auto_en) state_reg <= IDLE;
            else          gap_reg   <= gap_reg + GAP_W'(1);
          end
          SEL: begin
            cnt_reg                <= '0;
            {i2c_cmd, i2c_wr_data} <= byte_cmd(3'd0, ch_reg);
            i2c_cmd_vld            <= 1'b1;
            state_reg              <= ISSUE;
          end
          ISSUE: begin
            // The issue clock counts as the first clock of the timeout window.
            tmo_reg   <= TMO_W'(1);
            state_reg <= WAIT;
          end
          WAIT: begin
            if (i2c_done) begin
              cnt_reg <= cnt_reg + 3'd1;
              if (cnt_reg == LAST_CNT) begin
                state_reg <= STORE;
              end else begin
                {i2c_cmd, i2c_wr_data} <= byte_cmd(cnt_reg + 3'd1, ch_reg);
                i2c_cmd_vld            <= 1'b1;
                state_reg              <= ISSUE;
              end
            end else if (tmo_reg >= TMO_W'(TIMEOUT_CYC - 1)) begin
              err       <= 1'b1;
              err_ch    <= ch_reg;
              busy      <= 1'b0;
              state_reg <= IDLE;
`ifdef ADC_SCAN_AVG_EN
              acc_reg   <= '0;
              conv_reg  <= '0;
`endif
            end else begin
              tmo_reg <= tmo_reg + TMO_W'(1);
            end
          end
          STORE: begin
`ifdef ADC_SCAN_AVG_EN
            if (conv_reg == 2'd3) begin
              result_reg[ch_reg] <= acc_sum[DATA_W+1:2];
              sample_vld         <= 1'b1;
              sample_ch          <= ch_reg;
              sample_data        <= acc_sum[DATA_W+1:2];
              acc_reg            <= '0;
              conv_reg           <= '0;
              state_reg          <= NEXT;
            end else begin
              acc_reg   <= acc_sum;
              conv_reg  <= conv_reg + 2'd1;
              state_reg <= SEL;
            end
`else
            result_reg[ch_reg] <= sample;
            sample_vld         <= 1'b1;
            sample_ch          <= ch_reg;
            sample_data        <= sample;
            state_reg          <= NEXT;
`endif
          end
          NEXT: begin
            if (next_found) begin
              ch_reg    <= next_ch;
              state_reg <= SEL;
            end else begin
              scan_done <= 1'b1;
              busy      <= 1'b0;
              gap_reg   <= '0;
              state_reg <= auto_en ? GAP : IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
- Parametrised multi-channel ADC scan sequencer. It is the successor to the single-register ADC read controller.
- Drives the existing i2c byte engine through its cmd/cmd_vld/wr_data/rd_data/rd_data_vld/done interface. The engine is instantiated outside this block, and this block connects to it through dedicated ports.
- Per enabled channel, it writes a channel-select config byte, reads RD_BYTES bytes, extracts a DATA_W-bit sample and stores it in a per-channel result register.
- Supports one-shot scans and periodic auto-scan, plus a transaction timeout.

Parameters:
- NUM_CH, 4: number of ADC channels, 1..8.
- DATA_W, 12: sample width, 1..16.
- RD_BYTES, 2: bytes read per conversion, 1..2.
- ALIGN_SHIFT, 4: right shift applied to the concatenated read bytes (first byte = MSB) before truncating to DATA_W.
- DEV_ID, 7'h48: 7-bit I2C device address.
- CFG_BASE, 8'h40: config byte for channel n is CFG_BASE | n.
- SCAN_GAP, 50000: idle clocks between auto-scans.
- TIMEOUT_CYC, 100000: maximum clocks waiting for engine done.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin one scan
- auto_en  in  1  level; rescan every SCAN_GAP clocks after each scan ends
- ch_mask  in  NUM_CH  channel enable; sampled at scan start
- busy  out  1  high from scan start to scan end
- scan_done  out  1  one-cycle pulse at scan end
- sample_vld  out  1  one-cycle pulse when a result is stored
- sample_ch  out  3  channel of the current sample_vld
- sample_data  out  DATA_W  value of the current sample_vld
- rd_sel  in  3  result register select
- rd_result  out  DATA_W  combinational read of the result register at rd_sel; 0 if rd_sel >= NUM_CH
- err  out  1  one-cycle pulse on timeout
- err_ch  out  3  channel active at the timeout, held until the next err
- i2c_cmd  out  5  engine command: {ACK,STOP,READ,WRITE,START} bits 4..0
- i2c_cmd_vld  out  1  engine command strobe
- i2c_wr_data  out  8  engine write byte
- i2c_rd_data  in  8  engine read byte
- i2c_rd_data_vld  in  1  engine read byte valid
- i2c_done  in  1  engine byte complete

Behaviour:
- Reset (asynchronous, rst=0): every output register is 0, including the result registers, i2c_cmd, i2c_cmd_vld, i2c_wr_data, err_ch and busy. FSM returns to IDLE.
- Reset mid-transfer: the engine shares rst, so it is reset at the same time.

States and transitions:
- IDLE → SEL on a start pulse or an auto trigger, when ch_mask != 0. The mask is latched, ch = lowest set bit, busy=1.
- start with ch_mask == 0: no transfers. busy stays 0, and scan_done pulses on the following cycle.
- start while busy: ignored.
- SEL → ISSUE: loads the byte counter and the command for the current byte.
- ISSUE: i2c_cmd_vld=1 for exactly one clock, with i2c_cmd and i2c_wr_data held stable until i2c_done → WAIT.
- WAIT: on i2c_done, byte counter +1.
  - If bytes remain → ISSUE. The next command is issued on the clock after done; there is no back-to-back issue.
  - Otherwise → STORE.

Byte sequence per channel (cnt 0..3+RD_BYTES-1):
- cnt 0: START|WRITE, data {DEV_ID,0}.
- cnt 1: WRITE, data CFG_BASE|ch.
- cnt 2: START|WRITE, data {DEV_ID,1}.
- cnt 3..: READ. The last read byte is READ|STOP; the engine NACKs it.

Data capture and storage:
- On each i2c_rd_data_vld, shift_reg <= {shift_reg[7:0], i2c_rd_data}.
- STORE: sample = (shift_reg >> ALIGN_SHIFT)[DATA_W-1:0]. It is written to result[ch], and sample_vld/sample_ch/sample_data are registered for 1 clock. Then go to NEXT.
- NEXT: ch = next set bit above ch → SEL. If there is none: scan_done pulse, busy=0, → GAP if auto_en, else IDLE.
- GAP: counts SCAN_GAP clocks, then starts a new scan with a freshly sampled ch_mask.
  - auto_en low in GAP → IDLE immediately.
  - A start pulse in GAP starts a scan immediately.
- auto_en dropping mid-scan: the current scan completes, then the FSM goes to IDLE.

Timeout:
- The counter clears on each ISSUE.
- If it reaches TIMEOUT_CYC in WAIT: err pulse, err_ch=ch, scan aborted (no scan_done, busy=0) → IDLE.
- The result register of the aborted channel is unchanged.

Misc:
- Simultaneous i2c_done and i2c_rd_data_vld: the byte is captured before STORE evaluates.
- rd_result update: reflects a new value the clock after STORE.

Optional Feature:
- Macro: ADC_SCAN_AVG_EN.
- Defined: each channel is converted 4 times consecutively, restarting from cnt 0 each time. Samples are summed in a DATA_W+2 accumulator. STORE writes sum>>2 (truncating), and sample_vld pulses once per channel, after the 4th conversion. A timeout during any of the 4 conversions discards the accumulator.
- Not defined: one conversion per channel; no accumulator logic is synthesised.

Test Plan:
- Defaults, ch_mask=4'b0101, start pulse, engine model returns 0xAB,0xC0 for ch0 and 0x12,0x30 for ch2 → wr_data sequence 0x90,0x40,0x91 then 0x90,0x42,0x91; sample_vld twice (ch0=0xABC, ch2=0x123); one scan_done; rd_sel=2 gives rd_result=0x123.
- ch_mask=0, start → no i2c_cmd_vld; scan_done pulses 1 clock later; busy stays 0.
- auto_en=1, SCAN_GAP=10, mask=4'b0001 → second scan's first i2c_cmd_vld occurs exactly 10 clocks after GAP entry (plus 1 SEL clock); start during busy is ignored.
- Engine withholds done on cnt 3 for ch1, TIMEOUT_CYC=20 → err pulse 20 clocks after ISSUE, err_ch=1, busy=0, no scan_done, result[1] unchanged.
- Reset asserted during WAIT → outputs 0 in the same cycle; FSM in IDLE; a later start completes normally.
- ADC_SCAN_AVG_EN, reads 0x100,0x101,0x102,0x103 (12-bit) → single sample_vld with 0x101.
